// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter.
//   MODE_FIXED / MODE_RR : grant policy selectors for the MODE parameter
//   MAX_PORTS / IDX_W    : widest supported requester vector and its index width
//   onehot_to_index()    : converts a one-hot grant (zero-extended to MAX_PORTS)
//                          into a binary port index
package mem_arb_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  localparam int MAX_PORTS = 8;
  localparam int IDX_W     = 3;

  // OR-reduction of the set bit positions; correct for one-hot or all-zero input.
  function automatic logic [IDX_W-1:0] onehot_to_index(input logic [MAX_PORTS-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_grant.sv
// Combinational grant selection.
//   eligible : per-port "may be granted this cycle" vector
//   ptr      : round-robin search start (ignored in fixed-priority mode)
//   grant    : one-hot winner, all zero when nothing is eligible
//   valid    : some port is granted
module arb_grant
  import mem_arb_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int MODE   = MODE_FIXED
) (
  input  logic [NPORTS-1:0]         eligible,
  input  logic [$clog2(NPORTS)-1:0] ptr,
  output logic [NPORTS-1:0]         grant,
  output logic                      valid
);

  localparam int PW = $clog2(NPORTS);

  int             start;
  int             idx;
  logic [PW-1:0]  sel;
  logic           found;

  // Walk the ports starting at 'start', wrapping at NPORTS; first eligible wins.
  // Fixed priority is the same walk anchored at port 0.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    start = (MODE == MODE_RR) ? int'(ptr) : 0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = start + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      sel = PW'(idx);
      if (!found && eligible[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid = |eligible;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported synchronous memory among NPORTS requesters.
// At most one access is issued per clock; each requester holds a level
// read/write request until it sees its one-cycle rdy pulse.
//   clk, reset          : clock, synchronous active-high reset
//   req_rd / req_wr     : per-port read / write request (write wins if both)
//   req_addr/req_wdata  : per-port address / write data, port i at [i*W +: W]
//   rdy                 : per-port completion pulse, cycle after the grant
//   rd_data             : memory read data, meaningful for the port with rdy
//   mem_addr/mem_wdata  : memory address / write data of the granted port
//   mem_we / mem_re     : memory write / read enable
//   mem_rdata           : memory read data, valid the cycle after mem_re
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NPORTS = 3,
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16,
  parameter int MODE   = MODE_FIXED
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        req_rd,
  input  logic [NPORTS-1:0]        req_wr,
  input  logic [NPORTS*AWIDTH-1:0] req_addr,
  input  logic [NPORTS*DWIDTH-1:0] req_wdata,
  output logic [NPORTS-1:0]        rdy,
  output logic [DWIDTH-1:0]        rd_data,
  output logic [AWIDTH-1:0]        mem_addr,
  output logic [DWIDTH-1:0]        mem_wdata,
  output logic                     mem_we,
  output logic                     mem_re,
  input  logic [DWIDTH-1:0]        mem_rdata
);

  localparam int PW = $clog2(NPORTS);

  logic [NPORTS-1:0] pending;
  logic [NPORTS-1:0] eligible;
  logic [NPORTS-1:0] grant;
  logic              grant_valid;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     gidx;

  logic [AWIDTH-1:0] addr_arr  [NPORTS];
  logic [DWIDTH-1:0] wdata_arr [NPORTS];

  for (genvar i = 0; i < NPORTS; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*AWIDTH +: AWIDTH];
    assign wdata_arr[i] = req_wdata[i*DWIDTH +: DWIDTH];
  end

  // A port that was granted last cycle is still holding its request while
  // its rdy pulses; masking it out prevents a duplicate access.
  assign eligible = (req_rd | req_wr) & ~pending;

  arb_grant #(
    .NPORTS (NPORTS),
    .MODE   (MODE)
  ) u_grant (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .valid    (grant_valid)
  );

  assign gidx = PW'(onehot_to_index(MAX_PORTS'(grant)));

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (grant_valid) begin
      mem_addr  = addr_arr[gidx];
      mem_wdata = wdata_arr[gidx];
      // A write presented during reset must not reach the memory.
      mem_we    = req_wr[gidx] & ~reset;
      mem_re    = req_rd[gidx] & ~req_wr[gidx];
    end
  end

  // The granted one-hot, delayed a cycle, is both the completion pulse and
  // the "do not re-grant" mask, so a single register serves as both.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      ptr     <= '0;
    end else begin
      pending <= grant;
      if (MODE == MODE_RR && grant_valid) begin
        ptr <= (gidx == PW'(NPORTS - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  assign rdy     = pending;
  assign rd_data = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Two arbiters side by side: instance 0 in fixed-priority mode, instance 1
// in round-robin mode, each with its own memory, reference model and
// scoreboard. The reference model predicts grants from the arbitration
// rules and keeps its own copy of memory contents.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int NPORTS = 3;
  localparam int AWIDTH = 16;
  localparam int DWIDTH = 16;
  localparam int NI     = 2;

  typedef struct {
    logic [NPORTS-1:0] rdy;
    logic              rd;
    logic [DWIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic                     rst_s       [NI];
  logic [NPORTS-1:0]        req_rd_s    [NI];
  logic [NPORTS-1:0]        req_wr_s    [NI];
  logic [NPORTS*AWIDTH-1:0] req_addr_s  [NI];
  logic [NPORTS*DWIDTH-1:0] req_wdata_s [NI];
  logic [NPORTS-1:0]        rdy_s       [NI];
  logic [DWIDTH-1:0]        rd_data_s   [NI];
  logic [AWIDTH-1:0]        mem_addr_s  [NI];
  logic [DWIDTH-1:0]        mem_wdata_s [NI];
  logic                     mem_we_s    [NI];
  logic                     mem_re_s    [NI];

  logic              active   [NI][NPORTS];
  logic [DWIDTH-1:0] last_rd  [NI][NPORTS];
  int                done_cnt [NI][NPORTS];

  function automatic logic [DWIDTH-1:0] init_val(input logic [7:0] a);
    return (a == 8'h12) ? 16'hBEEF : {8'h5A, a};
  endfunction

  task automatic check(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (inst %0d): got %h, expected %h at %0t", name, m, act, exp, $time);
    end
  endtask

  for (genvar m = 0; m < NI; m++) begin : g_inst
    logic [DWIDTH-1:0] mem_rdata;
    logic [DWIDTH-1:0] dev_mem [256];
    logic [DWIDTH-1:0] ref_mem [256];
    exp_t              exp_q [$];
    exp_t              e;
    logic [NPORTS-1:0] m_pend;
    logic [NPORTS-1:0] prev_rdy;
    int                m_ptr;
    int                w;
    int                p;
    logic              wr;
    logic [AWIDTH-1:0] a;
    logic [DWIDTH-1:0] d;

    mem_arbiter #(
      .NPORTS (NPORTS),
      .AWIDTH (AWIDTH),
      .DWIDTH (DWIDTH),
      .MODE   (m)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_s[m]),
      .req_rd    (req_rd_s[m]),
      .req_wr    (req_wr_s[m]),
      .req_addr  (req_addr_s[m]),
      .req_wdata (req_wdata_s[m]),
      .rdy       (rdy_s[m]),
      .rd_data   (rd_data_s[m]),
      .mem_addr  (mem_addr_s[m]),
      .mem_wdata (mem_wdata_s[m]),
      .mem_we    (mem_we_s[m]),
      .mem_re    (mem_re_s[m]),
      .mem_rdata (mem_rdata)
    );

    initial begin
      for (int i = 0; i < 256; i++) begin
        dev_mem[i] = init_val(8'(i));
        ref_mem[i] = init_val(8'(i));
      end
      m_pend   = '0;
      m_ptr    = 0;
      prev_rdy = '0;
    end

    // Synchronous single-ported memory device.
    initial forever begin
      @(posedge clk);
      if (mem_we_s[m] === 1'b1) dev_mem[mem_addr_s[m][7:0]] <= mem_wdata_s[m];
      if (mem_re_s[m] === 1'b1) mem_rdata <= dev_mem[mem_addr_s[m][7:0]];
    end

    // Reference model: mid-cycle, decide which port the rules say wins,
    // check the memory-side outputs, and queue the expected rdy/data.
    initial forever begin
      @(negedge clk);
      if (rst_s[m] !== 1'b0) begin
        check("mem_we_during_reset", m, 32'(mem_we_s[m]), 32'd0);
        exp_q.push_back('{rdy: '0, rd: 1'b0, data: '0});
        m_pend = '0;
        m_ptr  = 0;
      end else begin
        w = -1;
        for (int k = 0; k < NPORTS; k++) begin
          p = (m == MODE_RR) ? (m_ptr + k) % NPORTS : k;
          if (w < 0 && (req_rd_s[m][p] || req_wr_s[m][p]) && !m_pend[p]) w = p;
        end
        if (w >= 0) begin
          wr = req_wr_s[m][w];
          a  = req_addr_s[m][w*AWIDTH +: AWIDTH];
          d  = req_wdata_s[m][w*DWIDTH +: DWIDTH];
          check("mem_addr", m, 32'(mem_addr_s[m]), 32'(a));
          check("mem_we", m, 32'(mem_we_s[m]), 32'(wr));
          check("mem_re", m, 32'(mem_re_s[m]), 32'(!wr));
          if (wr) begin
            check("mem_wdata", m, 32'(mem_wdata_s[m]), 32'(d));
            ref_mem[a[7:0]] = d;
            exp_q.push_back('{rdy: NPORTS'(1) << w, rd: 1'b0, data: '0});
          end else begin
            exp_q.push_back('{rdy: NPORTS'(1) << w, rd: 1'b1, data: ref_mem[a[7:0]]});
          end
          m_pend = NPORTS'(1) << w;
          if (m == MODE_RR) m_ptr = (w + 1) % NPORTS;
        end else begin
          check("idle_mem_we", m, 32'(mem_we_s[m]), 32'd0);
          check("idle_mem_re", m, 32'(mem_re_s[m]), 32'd0);
          check("idle_mem_addr", m, 32'(mem_addr_s[m]), 32'd0);
          check("idle_mem_wdata", m, 32'(mem_wdata_s[m]), 32'd0);
          exp_q.push_back('{rdy: '0, rd: 1'b0, data: '0});
          m_pend = '0;
        end
      end
    end

    // Monitor: compare what the arbiter presents after each edge.
    initial forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rdy", m, 32'(rdy_s[m]), 32'(e.rdy));
        if (e.rd) check("rd_data", m, 32'(rd_data_s[m]), 32'(e.data));
        check("rdy_back_to_back", m, 32'(rdy_s[m] & prev_rdy), 32'd0);
        prev_rdy = rdy_s[m];
      end
    end
  end

  task automatic set_port(input int m, input int p, input logic rd, input logic wr,
                          input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
    req_rd_s[m][p] = rd;
    req_wr_s[m][p] = wr;
    req_addr_s[m][p*AWIDTH +: AWIDTH]  = a;
    req_wdata_s[m][p*DWIDTH +: DWIDTH] = d;
    active[m][p] = rd | wr;
  endtask

  // Advance one cycle and retire every request whose rdy is now pulsing.
  task automatic step();
    @(posedge clk);
    #1;
    for (int m = 0; m < NI; m++) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (active[m][p] && rdy_s[m][p] === 1'b1) begin
          if (req_rd_s[m][p] && !req_wr_s[m][p]) last_rd[m][p] = rd_data_s[m];
          set_port(m, p, 1'b0, 1'b0, '0, '0);
          done_cnt[m][p]++;
        end
      end
    end
  endtask

  function automatic logic [NPORTS-1:0] busy(input int m);
    logic [NPORTS-1:0] b;
    for (int p = 0; p < NPORTS; p++) b[p] = active[m][p];
    return b;
  endfunction

  task automatic drain(input int m, input int budget);
    int n;
    n = 0;
    while (busy(m) != '0 && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", m, 32'(busy(m)), 32'd0);
  endtask

  initial begin
    int c0 [NPORTS];
    int kind;
    for (int m = 0; m < NI; m++) begin
      rst_s[m] = 1'b1;
      req_rd_s[m] = '0;
      req_wr_s[m] = '0;
      req_addr_s[m] = '0;
      req_wdata_s[m] = '0;
      for (int p = 0; p < NPORTS; p++) begin
        active[m][p]   = 1'b0;
        last_rd[m][p]  = '0;
        done_cnt[m][p] = 0;
      end
    end
    repeat (3) step();
    check("reset_rdy_0", 0, 32'(rdy_s[0]), 32'd0);
    check("reset_rdy_1", 1, 32'(rdy_s[1]), 32'd0);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;

    for (int m = 0; m < NI; m++) begin
      // Single uncontended read, one-cycle latency.
      step();
      set_port(m, 1, 1'b1, 1'b0, 16'h0012, '0);
      step();
      check("single_read_latency", m, 32'(active[m][1]), 32'd0);
      check("single_read_data", m, 32'(last_rd[m][1]), 32'hBEEF);

      // Three ports reading continuously.
      for (int p = 0; p < NPORTS; p++) c0[p] = done_cnt[m][p];
      for (int c = 0; c < 12; c++) begin
        for (int p = 0; p < NPORTS; p++)
          if (!active[m][p]) set_port(m, p, 1'b1, 1'b0, AWIDTH'(16 + p), '0);
        step();
      end
      for (int p = 0; p < NPORTS; p++)
        check($sformatf("contention_count_p%0d", p), m, 32'(done_cnt[m][p] - c0[p]),
              (m == MODE_RR) ? 32'd4 : ((p == 2) ? 32'd0 : 32'd6));
      drain(m, 20);

      // Write then read back on the same port.
      set_port(m, 0, 1'b0, 1'b1, 16'h0005, 16'h1234);
      drain(m, 10);
      set_port(m, 0, 1'b1, 1'b0, 16'h0005, '0);
      drain(m, 10);
      check("write_then_read", m, 32'(last_rd[m][0]), 32'h1234);

      // Debug write and CPU read contend for the same address.
      step();
      set_port(m, 2, 1'b0, 1'b1, 16'h0007, 16'h5555);
      set_port(m, 0, 1'b1, 1'b0, 16'h0007, '0);
      step();
      if (m == MODE_FIXED) begin
        check("mixed_port0_first", m, 32'(busy(m)), 32'b100);
        step();
        check("mixed_port2_next", m, 32'(busy(m)), 32'd0);
        check("mixed_read_old", m, 32'(last_rd[m][0]), 32'h5A07);
      end
      drain(m, 10);
      set_port(m, 1, 1'b1, 1'b0, 16'h0007, '0);
      drain(m, 10);
      check("mixed_final_mem", m, 32'(last_rd[m][1]), 32'h5555);

      // Reset asserted in the grant cycle of a write.
      step();
      set_port(m, 0, 1'b0, 1'b1, 16'h0009, 16'hDEAD);
      rst_s[m] = 1'b1;
      step();
      rst_s[m] = 1'b0;
      set_port(m, 0, 1'b0, 1'b0, '0, '0);
      check("rdy_after_reset", m, 32'(rdy_s[m]), 32'd0);
      for (int p = 0; p < NPORTS; p++) set_port(m, p, 1'b1, 1'b0, 16'h0009, '0);
      step();
      check("post_reset_port0_first", m, 32'(busy(m)), 32'b110);
      check("reset_write_dropped", m, 32'(last_rd[m][0]), 32'h5A09);
      drain(m, 10);

      // Randomized traffic, including simultaneous rd+wr and abandoned requests.
      for (int c = 0; c < 300; c++) begin
        for (int p = 0; p < NPORTS; p++) begin
          if (!active[m][p]) begin
            if ($urandom_range(0, 1) == 1) begin
              kind = int'($urandom_range(0, 2));
              set_port(m, p, kind != 1, kind != 0, AWIDTH'($urandom_range(0, 15)), DWIDTH'($urandom));
            end
          end else if ($urandom_range(0, 15) == 0) begin
            set_port(m, p, 1'b0, 1'b0, '0, '0);
          end
        end
        step();
      end
      drain(m, 20);
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
N-port request/ready arbiter that shares one single-ported synchronous memory (e.g. sram, vram write port) among CPU instruction fetch, CPU data and the SPI debug interface. It replaces the always-grant fake arbitration. Each requester holds a read or write request until it sees a one-cycle ready pulse. The grant policy is selectable between fixed priority and round-robin, and the block issues at most one memory access per clock.

Parameters:
NPORTS, 3, number of requesters (2..8)
AWIDTH, 16, address width
DWIDTH, 16, data width
MODE, 0, 0 = fixed priority (port 0 highest), 1 = round-robin

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_rd  input  NPORTS  per-port read request, level, held until rdy
req_wr  input  NPORTS  per-port write request, level, held until rdy
req_addr  input  NPORTS*AWIDTH  per-port address; port i occupies bits [i*AWIDTH +: AWIDTH]
req_wdata  input  NPORTS*DWIDTH  per-port write data, same packing
rdy  output  NPORTS  per-port one-cycle completion pulse
rd_data  output  DWIDTH  read data, broadcast to all ports, valid only for the port whose rdy is high
mem_addr  output  AWIDTH  memory address
mem_wdata  output  DWIDTH  memory write data
mem_we  output  1  memory write enable
mem_re  output  1  memory read enable
mem_rdata  input  DWIDTH  memory read data, valid one cycle after mem_re

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- On reset: rdy=0, pending=0, RR pointer=0.
- mem_* are combinational from the current grant. With no grant: mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
- rd_data = mem_rdata, passed through unchanged.
- Eligible port i: (req_rd[i] | req_wr[i]) & ~pending[i].
  - pending[i] is registered and set in the cycle after port i is granted.
  - Result: a port is never re-granted while its rdy is pulsing.
- Grant cycle T: exactly one eligible port g is granted.
  - g drives mem_addr and mem_wdata.
  - mem_we = req_wr[g]; mem_re = req_rd[g] & ~req_wr[g].
  - rd and wr both high on one port: treated as a write, single rdy.
- Cycle T+1: rdy[g]=1 and pending[g]=1. For a read, rd_data is valid in this cycle. pending[g] clears at T+2.
- Latency: request to rdy is 1 cycle when uncontended.
- Throughput: one access per cycle across different ports; the same port gets at most one access per 2 cycles.
- MODE 0: lowest-index eligible port wins.
- MODE 1: search starts at ptr and wraps modulo NPORTS; after a grant to g, ptr = (g+1) mod NPORTS. With no grant, ptr holds.
- A requester dropping its request before rdy: the access is abandoned only if it was not yet granted. A granted access always completes and rdy still pulses.
- Reset mid-access: the rdy for that access is suppressed (0 in the cycle after reset). Writes issued in the reset cycle are not performed: mem_we is forced 0 while reset is high.
- No state machine beyond the pending vector, the rdy register and ptr.

Decomposition:
- Shared package mem_arb_pkg:
  - MODE_FIXED=0, MODE_RR=1.
  - Function onehot_to_index.
- Sub-module arb_grant: NPORTS, MODE; inputs eligible vector and ptr; output onehot grant and valid. Purely combinational.
- mem_arbiter keeps the registers (pending, rdy, ptr) and the port muxes.

Test Plan:
- Single read: port1 req_rd, addr 0x0012, memory preloaded 0xBEEF -> mem_re=1 at T, rdy[1]=1 and rd_data=0xBEEF at T+1, rdy low at T+2.
- Contention, MODE 0: ports 0,1,2 read continuously -> grants 0,1,0,1,...; port 2 starves. Verify no rdy on any port in two consecutive cycles.
- Contention, MODE 1: same stimulus -> grant sequence 0,1,2,0,1,2. Each rdy arrives exactly 1 cycle after its grant.
- Write then read, same port: port0 writes 0x1234 to addr 5, then reads addr 5 after its rdy -> second rdy carries rd_data=0x1234; mem_we high exactly one cycle.
- Mixed priority: port2 (debug) writes while port0 reads, MODE 0 -> port0 granted first, port2 next cycle. Both rdys exactly once; memory contents correct.
- Reset mid-access: assert reset in the grant cycle of a write -> no mem_we, no rdy; after reset ptr=0, pending=0, and a fresh request completes normally.
